// File: rtl/lycan_globals.sv
// Project-wide constants shared by the peripheral data path.
//   usb_packet_width  : width of a de-addressed USB packet word
//   periph_fifo_depth : default depth of the per-peripheral bridge FIFOs
package lycan_globals;

    localparam int unsigned usb_packet_width  = 8;
    localparam int unsigned periph_fifo_depth = 16;

    typedef logic [usb_packet_width-1:0] usb_packet_t;

endpackage : lycan_globals

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers only)
//   flush_i       : synchronous clear, wins over any read/write that cycle
//   wr_en_i/wr_data_i : write request, ignored while full
//   rd_en_i       : pop request, ignored while empty
//   rd_data_o     : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : status from registered pointers
// Build option: PERIPH_FIFO_DIAG_EN enables count_o; otherwise it is tied to 0.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    wr_en_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    rd_en_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PtrW = AW + 1;

    // MSB of each pointer is the wrap bit distinguishing full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_fire, rd_fire;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_fire   = wr_en_i & ~full_o;
    assign rd_fire   = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (rd_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; occupancy is defined purely by the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_fire && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

`ifdef PERIPH_FIFO_DIAG_EN
    assign count_o = wr_ptr_q - rd_ptr_q;
`else
    assign count_o = '0;
`endif

endmodule : sync_fifo

// File: rtl/periph_fifo_bridge.sv
// Per-peripheral FIFO pair at the far end of the peripheral data interface.
//   clk, rst_n          : clock, asynchronous active-low reset
//   host_tx_*           : router -> TX FIFO write (valid/ready)
//   tx_data/tx_empty/tx_read : TX FIFO head toward the peripheral (FWFT)
//   rx_data/rx_valid/rx_fifo_full : peripheral -> RX FIFO write
//   host_rx_*           : RX FIFO head toward the router (valid/ready)
//   periph_idle, bridge_idle : quiescence in/out
//   flush               : synchronous clear of both FIFOs and error flags
//   tx_underflow, rx_overflow, tx_count, rx_count : diagnostics
// Build option: PERIPH_FIFO_DIAG_EN makes the diagnostics live; when undefined
// they read 0 and the flag registers are not built.
module periph_fifo_bridge
    import lycan_globals::*;
#(
    parameter int unsigned TX_DEPTH = periph_fifo_depth,
    parameter int unsigned RX_DEPTH = periph_fifo_depth
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [usb_packet_width-1:0]  host_tx_data,
    input  logic                         host_tx_valid,
    output logic                         host_tx_ready,
    output logic [usb_packet_width-1:0]  tx_data,
    output logic                         tx_empty,
    input  logic                         tx_read,
    input  logic [usb_packet_width-1:0]  rx_data,
    input  logic                         rx_valid,
    output logic                         rx_fifo_full,
    output logic [usb_packet_width-1:0]  host_rx_data,
    output logic                         host_rx_valid,
    input  logic                         host_rx_ready,
    input  logic                         periph_idle,
    input  logic                         flush,
    output logic                         bridge_idle,
    output logic                         tx_underflow,
    output logic                         rx_overflow,
    output logic [$clog2(TX_DEPTH):0]    tx_count,
    output logic [$clog2(RX_DEPTH):0]    rx_count
);

    logic tx_full;
    logic rx_empty;

    sync_fifo #(
        .WIDTH (usb_packet_width),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .wr_en_i   (host_tx_valid),
        .wr_data_i (host_tx_data),
        .rd_en_i   (tx_read),
        .rd_data_o (tx_data),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .count_o   (tx_count)
    );

    sync_fifo #(
        .WIDTH (usb_packet_width),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .wr_en_i   (rx_valid),
        .wr_data_i (rx_data),
        .rd_en_i   (host_rx_ready),
        .rd_data_o (host_rx_data),
        .full_o    (rx_fifo_full),
        .empty_o   (rx_empty),
        .count_o   (rx_count)
    );

    assign host_tx_ready = ~tx_full;
    assign host_rx_valid = ~rx_empty;
    assign bridge_idle   = tx_empty & rx_empty & periph_idle;

`ifdef PERIPH_FIFO_DIAG_EN
    logic tx_underflow_q, tx_underflow_d;
    logic rx_overflow_q, rx_overflow_d;

    always_comb begin
        tx_underflow_d = tx_underflow_q | (tx_read & tx_empty);
        rx_overflow_d  = rx_overflow_q | (rx_valid & rx_fifo_full);
        if (flush) begin
            tx_underflow_d = 1'b0;
            rx_overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_underflow_q <= 1'b0;
            rx_overflow_q  <= 1'b0;
        end else begin
            tx_underflow_q <= tx_underflow_d;
            rx_overflow_q  <= rx_overflow_d;
        end
    end

    assign tx_underflow = tx_underflow_q;
    assign rx_overflow  = rx_overflow_q;
`else
    assign tx_underflow = 1'b0;
    assign rx_overflow  = 1'b0;
`endif

endmodule : periph_fifo_bridge

// File: tb/tb_periph_fifo_bridge.sv
// Self-checking bench for periph_fifo_bridge: a directed vector table plus
// hand-written sequences for fill/overflow, loopback, flush and async reset.
module tb_periph_fifo_bridge;

`ifdef PERIPH_FIFO_DIAG_EN
    localparam bit Diag = 1'b1;
`else
    localparam bit Diag = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_read;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_fifo_full;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic       periph_idle;
    logic       flush;
    logic       bridge_idle;
    logic       tx_underflow;
    logic       rx_overflow;
    logic [4:0] tx_count;
    logic [4:0] rx_count;

    // Direct drive, or loopback peripheral when loop_en is set.
    logic       loop_en;
    logic       drv_tx_read;
    logic       drv_rx_valid;
    logic [7:0] drv_rx_data;

    assign tx_read  = loop_en ? ~tx_empty : drv_tx_read;
    assign rx_valid = loop_en ? tx_read : drv_rx_valid;
    assign rx_data  = loop_en ? tx_data : drv_rx_data;

    always #5 clk = ~clk;

    periph_fifo_bridge #(
        .TX_DEPTH (16),
        .RX_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .tx_data       (tx_data),
        .tx_empty      (tx_empty),
        .tx_read       (tx_read),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_fifo_full  (rx_fifo_full),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .periph_idle   (periph_idle),
        .flush         (flush),
        .bridge_idle   (bridge_idle),
        .tx_underflow  (tx_underflow),
        .rx_overflow   (rx_overflow),
        .tx_count      (tx_count),
        .rx_count      (rx_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_tx_valid = 1'b0;
        host_tx_data  = 8'h00;
        drv_tx_read   = 1'b0;
        drv_rx_valid  = 1'b0;
        drv_rx_data   = 8'h00;
        host_rx_ready = 1'b0;
        flush         = 1'b0;
        periph_idle   = 1'b1;
    endtask

    // Inputs applied for one cycle; expected outputs just after that edge.
    typedef struct {
        logic       htv;
        logic [7:0] htd;
        logic       trd;
        logic       rv;
        logic [7:0] rd;
        logic       hrr;
        logic       fl;
        logic       pi;
        logic       e_tx_empty;
        logic       e_ready;
        logic [7:0] e_txd;
        logic       e_hrv;
        logic [7:0] e_hrd;
        logic       e_full;
        logic       e_bidle;
        int         e_txc;
        int         e_rxc;
        logic       e_uf;
        logic       e_of;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int sent;
        int got;
        int cyc;

        vecs[0]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 8'h11, 0, 0, 8'h00, 0, 0, 1,  0, 1, 8'h11, 0, 8'h00, 0, 0, 1, 0, 0, 0};
        vecs[2]  = '{1, 8'h22, 0, 0, 8'h00, 0, 0, 1,  0, 1, 8'h11, 0, 8'h00, 0, 0, 2, 0, 0, 0};
        vecs[3]  = '{1, 8'h33, 0, 0, 8'h00, 0, 0, 1,  0, 1, 8'h11, 0, 8'h00, 0, 0, 3, 0, 0, 0};
        vecs[4]  = '{1, 8'h44, 1, 0, 8'h00, 0, 0, 1,  0, 1, 8'h22, 0, 8'h00, 0, 0, 3, 0, 0, 0};
        vecs[5]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 1,  0, 1, 8'h33, 0, 8'h00, 0, 0, 2, 0, 0, 0};
        vecs[6]  = '{0, 8'h00, 0, 1, 8'hA5, 0, 0, 1,  0, 1, 8'h33, 1, 8'hA5, 0, 0, 2, 1, 0, 0};
        vecs[7]  = '{0, 8'h00, 0, 1, 8'h5A, 1, 0, 1,  0, 1, 8'h33, 1, 8'h5A, 0, 0, 2, 1, 0, 0};
        vecs[8]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1,  0, 1, 8'h33, 0, 8'h00, 0, 0, 2, 0, 0, 0};
        vecs[9]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 1,  0, 1, 8'h44, 0, 8'h00, 0, 0, 1, 0, 0, 0};
        vecs[10] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 1,  1, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0};
        vecs[11] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 1,  1, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 0};
        vecs[13] = '{1, 8'h77, 0, 1, 8'h99, 0, 1, 1,  1, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0};
        vecs[14] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1,  1, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0};

        loop_en = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        chk("rst tx_empty", 32'(tx_empty), 32'd1);
        chk("rst host_tx_ready", 32'(host_tx_ready), 32'd1);
        chk("rst host_rx_valid", 32'(host_rx_valid), 32'd0);
        chk("rst rx_fifo_full", 32'(rx_fifo_full), 32'd0);
        chk("rst tx_count", 32'(tx_count), 32'd0);
        chk("rst rx_count", 32'(rx_count), 32'd0);
        chk("rst tx_underflow", 32'(tx_underflow), 32'd0);
        chk("rst rx_overflow", 32'(rx_overflow), 32'd0);
        chk("rst bridge_idle", 32'(bridge_idle), 32'd1);
        periph_idle = 1'b0;
        #1;
        chk("rst bridge_idle follows periph_idle", 32'(bridge_idle), 32'd0);
        periph_idle = 1'b1;
        rst_n = 1'b1;
        cycle();

        // Vector table
        for (int i = 0; i < 15; i++) begin
            host_tx_valid = vecs[i].htv;
            host_tx_data  = vecs[i].htd;
            drv_tx_read   = vecs[i].trd;
            drv_rx_valid  = vecs[i].rv;
            drv_rx_data   = vecs[i].rd;
            host_rx_ready = vecs[i].hrr;
            flush         = vecs[i].fl;
            periph_idle   = vecs[i].pi;
            cycle();
            chk($sformatf("v%0d tx_empty", i), 32'(tx_empty), 32'(vecs[i].e_tx_empty));
            chk($sformatf("v%0d host_tx_ready", i), 32'(host_tx_ready), 32'(vecs[i].e_ready));
            if (!vecs[i].e_tx_empty)
                chk($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(vecs[i].e_txd));
            chk($sformatf("v%0d host_rx_valid", i), 32'(host_rx_valid), 32'(vecs[i].e_hrv));
            if (vecs[i].e_hrv)
                chk($sformatf("v%0d host_rx_data", i), 32'(host_rx_data), 32'(vecs[i].e_hrd));
            chk($sformatf("v%0d rx_fifo_full", i), 32'(rx_fifo_full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d bridge_idle", i), 32'(bridge_idle), 32'(vecs[i].e_bidle));
            chk($sformatf("v%0d tx_count", i), 32'(tx_count), Diag ? 32'(vecs[i].e_txc) : 32'd0);
            chk($sformatf("v%0d rx_count", i), 32'(rx_count), Diag ? 32'(vecs[i].e_rxc) : 32'd0);
            chk($sformatf("v%0d tx_underflow", i), 32'(tx_underflow),
                Diag ? 32'(vecs[i].e_uf) : 32'd0);
            chk($sformatf("v%0d rx_overflow", i), 32'(rx_overflow),
                Diag ? 32'(vecs[i].e_of) : 32'd0);
        end
        idle_inputs();

        // TX fill to full, then write+read on a full FIFO
        for (int i = 0; i < 16; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = 8'(i + 1);
            cycle();
            chk($sformatf("fill%0d host_tx_ready", i), 32'(host_tx_ready), (i == 15) ? 32'd0 : 32'd1);
        end
        chk("full tx_count", 32'(tx_count), Diag ? 32'd16 : 32'd0);
        chk("full tx_data", 32'(tx_data), 32'h01);
        host_tx_data = 8'hEE;
        drv_tx_read  = 1'b1;
        cycle();
        host_tx_valid = 1'b0;
        drv_tx_read   = 1'b0;
        chk("full rw tx_data", 32'(tx_data), 32'h02);
        chk("full rw tx_count", 32'(tx_count), Diag ? 32'd15 : 32'd0);
        chk("full rw host_tx_ready", 32'(host_tx_ready), 32'd1);
        // Back-to-back drain; the refused 0xEE must never appear.
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("drain%0d tx_data", i), 32'(tx_data), 32'(i));
            drv_tx_read = 1'b1;
            cycle();
        end
        drv_tx_read = 1'b0;
        chk("drain tx_empty", 32'(tx_empty), 32'd1);
        chk("drain tx_underflow", 32'(tx_underflow), 32'd0);

        // RX overflow: 17 pushes with the router stalled
        for (int i = 0; i < 17; i++) begin
            drv_rx_valid = 1'b1;
            drv_rx_data  = 8'(8'h80 + i);
            cycle();
            if (i == 15) chk("rx 16 rx_fifo_full", 32'(rx_fifo_full), 32'd1);
        end
        drv_rx_valid = 1'b0;
        chk("rx ovf rx_overflow", 32'(rx_overflow), Diag ? 32'd1 : 32'd0);
        chk("rx ovf rx_count", 32'(rx_count), Diag ? 32'd16 : 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rx pop%0d data", i), 32'(host_rx_data), 32'(8'h80 + i));
            host_rx_ready = 1'b1;
            cycle();
        end
        host_rx_ready = 1'b0;
        chk("rx drained host_rx_valid", 32'(host_rx_valid), 32'd0);
        chk("rx ovf sticky", 32'(rx_overflow), Diag ? 32'd1 : 32'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush rx_overflow", 32'(rx_overflow), 32'd0);

        // Loopback peripheral
        loop_en       = 1'b1;
        host_rx_ready = 1'b1;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((got < 8) && (cyc < 60)) begin
            host_tx_valid = (sent < 8);
            host_tx_data  = 8'(8'hC0 + sent);
            if (host_rx_valid) begin
                chk($sformatf("loop word%0d", got), 32'(host_rx_data), 32'(8'hC0 + got));
                got++;
            end
            if (host_tx_valid && host_tx_ready) sent++;
            cycle();
            cyc++;
        end
        host_tx_valid = 1'b0;
        chk("loop words received", 32'(got), 32'd8);
        chk("loop host_rx_valid", 32'(host_rx_valid), 32'd0);
        chk("loop bridge_idle", 32'(bridge_idle), 32'd1);
        loop_en       = 1'b0;
        host_rx_ready = 1'b0;

        // Asynchronous reset with 5 words queued
        for (int i = 0; i < 5; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = 8'(8'h50 + i);
            cycle();
        end
        host_tx_valid = 1'b0;
        chk("pre-reset tx_count", 32'(tx_count), Diag ? 32'd5 : 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst tx_empty", 32'(tx_empty), 32'd1);
        chk("async rst tx_count", 32'(tx_count), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post-reset tx_empty", 32'(tx_empty), 32'd1);
        chk("post-reset bridge_idle", 32'(bridge_idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_periph_fifo_bridge
